// File: rtl/scan_pkg.sv
// Shared definitions for the scan chip-select scheduler: FSM states, default
// sizing constants and the round-robin winner search.
package scan_pkg;

  localparam int DW_DEF      = 16;
  localparam int GAP_CYC_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  // First set bit of pend searching upward from last+1, wrapping at nch (nch <= 8).
  // Returns last when nothing is pending.
  function automatic int rr_next(input logic [7:0] pend, input int last, input int nch);
    int   idx;
    logic found;
    rr_next = last;
    found   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = (last + k) % nch;
      if (!found && (k <= nch) && pend[idx[2:0]]) begin
        rr_next = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/scan_req_sync.sv
// One trigger line: two-flop synchronizer plus a third flop for rising-edge detect.
module scan_req_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= req_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/scan_cs_sched.sv
// Round-robin scheduler granting one active-low chip-select window at a time,
// each window followed by a fixed all-high guard gap.
module scan_cs_sched
  import scan_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int GAP_CYC = GAP_CYC_DEF,
  parameter int DW      = DW_DEF,
  localparam int IW     = $clog2(NCH),
  localparam int GW     = $clog2(GAP_CYC + 1)
) (
  input  logic            clk24m,
  input  logic            rst,
  input  logic [NCH-1:0]  req,
  input  logic            enable,
  input  logic [DW-1:0]   dwell_cycles,
  input  logic            abort,
  output logic [NCH-1:0]  cs_n,
  output logic [IW-1:0]   gnt_id,
  output logic            busy,
  output logic            done,
  output logic [1:0]      dbg_state
);

  // Handshake: none. req is a free-running level; a synchronized rising edge
  // latches a pending request which is consumed by the grant that serves it.

  state_e          state_q, state_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [IW-1:0]   gnt_id_q, gnt_d;
  logic [NCH-1:0]  pend_q, pend_d;
  logic [NCH-1:0]  cs_n_q, cs_n_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [NCH-1:0]  rise;
  logic            grant;
  logic [IW-1:0]   win;
  logic [7:0]      pend_pad;

  for (genvar i = 0; i < NCH; i++) begin : g_sync
    scan_req_sync u_sync (
      .clk_i  (clk24m),
      .rst_i  (rst),
      .req_i  (req[i]),
      .rise_o (rise[i])
    );
  end

  always_comb begin
    pend_pad = '0;
    pend_pad[NCH-1:0] = pend_q;
    win = IW'(rr_next(pend_pad, int'(gnt_id_q), NCH));
  end

  always_ff @(posedge clk24m) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      gap_q    <= '0;
      gnt_id_q <= IW'(NCH - 1);
      pend_q   <= '0;
      cs_n_q   <= '1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      gnt_id_q <= gnt_d;
      pend_q   <= pend_d;
      cs_n_q   <= cs_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    gnt_d   = gnt_id_q;
    grant   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && (|pend_q)) begin
          grant   = 1'b1;
          gnt_d   = win;
          cnt_d   = (dwell_cycles == '0) ? DW'(1) : dwell_cycles;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (abort || (cnt_q == DW'(1))) begin
          gap_d   = GW'(GAP_CYC);
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - DW'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so cs_n falls on the grant edge.
  always_comb begin
    cs_n_d = '1;
    if (state_d == ST_ACTIVE) begin
      cs_n_d[gnt_d] = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_ACTIVE) && (cnt_q == DW'(1)) && !abort;
    pend_d = pend_q;
    if (grant) begin
      pend_d[win] = 1'b0;
    end
    pend_d = pend_d | rise;
  end

  assign cs_n      = cs_n_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_scan_cs_sched.sv
// Bench for scan_cs_sched: timestamp-based window model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_scan_cs_sched;

  localparam int NCH = 4;
  localparam int GAP = 3;
  localparam int DW  = 16;
  localparam int IW  = 2;

  logic            clk24m = 1'b0;
  logic            rst = 1'b1;
  logic [NCH-1:0]  req = '0;
  logic            enable = 1'b1;
  logic [DW-1:0]   dwell = 16'd5;
  logic            abort = 1'b0;
  logic [NCH-1:0]  cs_n;
  logic [IW-1:0]   gnt_id;
  logic            busy;
  logic            done;
  logic [1:0]      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk24m = ~clk24m;

  scan_cs_sched #(.NCH(NCH), .GAP_CYC(GAP), .DW(DW)) dut (
    .clk24m       (clk24m),
    .rst          (rst),
    .req          (req),
    .enable       (enable),
    .dwell_cycles (dwell),
    .abort        (abort),
    .cs_n         (cs_n),
    .gnt_id       (gnt_id),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // Reference model: each window is a pair of cycle timestamps [win_s, win_e),
  // followed by a gap [win_e, gap_e). Cycle t is the cycle following edge t.
  longint         t = 0, win_s = 0, win_e = 0, gap_e = 0;
  logic [NCH-1:0] m_pend = '0, m_s1 = '0, m_s2 = '0, m_s3 = '0;
  int             m_last = NCH - 1;
  bit             m_done = 1'b0;
  bit             m_valid = 1'b0;

  function automatic int phase_of(input longint c);
    if (c >= win_s && c < win_e) return 1;
    if (c >= win_e && c < gap_e) return 2;
    return 0;
  endfunction

  always @(posedge clk24m) begin : model
    int ph, w, idx;
    longint len;
    logic [NCH-1:0] m_rise;
    if (rst) begin
      m_pend = '0; m_s1 = '0; m_s2 = '0; m_s3 = '0;
      m_last = NCH - 1;
      m_done = 1'b0;
      win_s = t + 1; win_e = t + 1; gap_e = t + 1;
    end else begin
      m_rise = m_s2 & ~m_s3;
      ph = phase_of(t);
      m_done = 1'b0;
      if (ph == 1) begin
        if (abort) begin
          win_e = t + 1;
          gap_e = t + 1 + GAP;
        end else if (win_e == t + 1) begin
          m_done = 1'b1;
        end
      end else if (ph == 0 && enable && m_pend != '0) begin
        w = -1;
        for (int k = 1; k <= NCH; k++) begin
          idx = (m_last + k) % NCH;
          if (w < 0 && m_pend[idx[IW-1:0]]) w = idx;
        end
        len = (dwell == 0) ? 1 : longint'(dwell);
        win_s = t + 1;
        win_e = t + 1 + len;
        gap_e = win_e + GAP;
        m_last = w;
        m_pend[w[IW-1:0]] = 1'b0;
      end
      m_pend = m_pend | m_rise;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = req;
    end
    t = t + 1;
    m_valid = 1'b1;
  end

  always @(negedge clk24m) begin : compare
    int ph;
    logic [NCH-1:0] exp_cs;
    logic [IW-1:0]  exp_gnt;
    if (m_valid) begin
      ph = phase_of(t);
      exp_cs = '1;
      if (ph == 1) exp_cs[m_last[IW-1:0]] = 1'b0;
      exp_gnt = m_last[IW-1:0];
      n_tests++;
      if (cs_n !== exp_cs || gnt_id !== exp_gnt || busy !== (ph != 0) || done !== m_done) begin
        n_fail++;
        $display("FAIL cycle t=%0d got cs_n=%b gnt=%0d busy=%b done=%b, want cs_n=%b gnt=%0d busy=%b done=%b",
                 t, cs_n, gnt_id, busy, done, exp_cs, exp_gnt, (ph != 0), m_done);
      end
    end
  end

  task automatic tick();
    @(negedge clk24m);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    req = '0; abort = 1'b0; rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic wait_start(output int ch);
    int k = 0;
    ch = -1;
    while (cs_n == '1 && k < 200) begin tick(); k++; end
    if (cs_n == '1) begin
      n_tests++; n_fail++;
      $display("FAIL window_start_timeout got no window after %0d cycles", k);
    end else begin
      for (int i = 0; i < NCH; i++) if (!cs_n[i]) ch = i;
    end
  endtask

  task automatic measure(output int len, output bit dn);
    len = 0;
    while (cs_n != '1 && len < 1000) begin len++; tick(); end
    dn = done;
  endtask

  task automatic wait_window(output int ch, output int len, output bit dn);
    wait_start(ch);
    len = 0; dn = 1'b0;
    if (ch >= 0) measure(len, dn);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin tick(); k++; end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin : stim
    int ch, len, g;
    bit dn, seen_done;
    int order[$];

    do_reset();
    chk("reset_cs_n", cs_n, 4'hF);
    chk("reset_gnt", gnt_id, 3);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    // Single edge on ch2, dwell 5: 3-cycle latency, 5 low, done, 3-cycle gap.
    dwell = 16'd5; req[2] = 1'b1;
    ticks(3);
    chk("t1_pre_grant", cs_n, 4'hF);
    tick();
    chk("t1_cs_low", cs_n, 4'hB);
    chk("t1_gnt", gnt_id, 2);
    chk("t1_busy", busy, 1);
    ticks(4);
    chk("t1_cs_last", cs_n, 4'hB);
    tick();
    chk("t1_cs_high", cs_n, 4'hF);
    chk("t1_done", done, 1);
    ticks(2);
    chk("t1_gap3_busy", busy, 1);
    chk("t1_gap3_done", done, 0);
    tick();
    chk("t1_idle", busy, 0);
    req = '0;

    // Simultaneous edges on 0,1,3 after reset: order 0,1,3, each 2 cycles.
    do_reset();
    dwell = 16'd2; req = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      wait_window(ch, len, dn);
      order.push_back(ch);
      chk("t2_len", len, 2);
    end
    chk("t2_order0", order[0], 0);
    chk("t2_order1", order[1], 1);
    chk("t2_order2", order[2], 3);
    req = '0;
    wait_idle();

    // Fairness: after ch1 served, ch0 and ch1 together -> ch0 first.
    do_reset();
    dwell = 16'd1; req[1] = 1'b1;
    wait_window(ch, len, dn);
    chk("t3_first", ch, 1);
    wait_idle();
    req = '0; ticks(4);
    chk("t3_last_gnt", gnt_id, 1);
    req = 4'b0011;
    wait_window(ch, len, dn);
    chk("t3_rr0", ch, 0);
    wait_window(ch, len, dn);
    chk("t3_rr1", ch, 1);
    req = '0;
    wait_idle();

    // dwell 0 behaves as 1; dwell change mid-window has no effect.
    dwell = 16'd0; req[3] = 1'b1;
    wait_window(ch, len, dn);
    chk("t4_len_zero", len, 1);
    chk("t4_done_zero", dn, 1);
    wait_idle();
    req = '0; ticks(3);
    dwell = 16'd8; req[3] = 1'b1;
    wait_start(ch);
    dwell = 16'd2;
    measure(len, dn);
    chk("t4_len_sampled", len, 8);
    chk("t4_done_8", dn, 1);
    req = '0;
    wait_idle();

    // Abort on the 3rd cycle of a 10-cycle window.
    dwell = 16'd10; req[1] = 1'b1;
    wait_start(ch);
    ticks(2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_cs", cs_n, 4'hF);
    chk("t5_abort_busy", busy, 1);
    g = 0; seen_done = 1'b0;
    while (busy && g < 20) begin
      if (done) seen_done = 1'b1;
      g++; tick();
    end
    chk("t5_gap_len", g, 3);
    chk("t5_no_done", seen_done, 0);
    req = '0;

    // enable low blocks grants while pend latches.
    do_reset();
    enable = 1'b0; dwell = 16'd6; req[1] = 1'b1;
    ticks(10);
    chk("t6_no_grant_busy", busy, 0);
    chk("t6_no_grant_cs", cs_n, 4'hF);
    enable = 1'b1;
    wait_start(ch);
    chk("t6_grant_after_en", ch, 1);

    // Reset mid-window: chip-selects release on that edge, pend cleared.
    ticks(2);
    req = '0; rst = 1'b1;
    tick();
    chk("t7_rst_cs", cs_n, 4'hF);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_gnt", gnt_id, 3);
    rst = 1'b0;
    ticks(10);
    chk("t7_pend_clear", busy, 0);

    // Re-edge of the active channel: re-served after the other pending one.
    dwell = 16'd6; req = 4'b0101;
    wait_start(ch);
    chk("t8_first", ch, 0);
    tick(); req[0] = 1'b0;
    ticks(2); req[0] = 1'b1;
    measure(len, dn);
    wait_window(ch, len, dn);
    chk("t8_second", ch, 2);
    wait_window(ch, len, dn);
    chk("t8_reserve", ch, 0);
    req = '0;
    wait_idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 7) == 0) req[c] = ~req[c];
      dwell  = 16'($urandom_range(0, 6));
      enable = ($urandom_range(0, 9) != 0);
      abort  = ($urandom_range(0, 15) == 0);
      rst    = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0; abort = 1'b0; req = '0; enable = 1'b1;
    ticks(80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_cs_sched.md
# scan_cs_sched

Round-robin chip-select scheduler for the scan front end. It takes N asynchronous scan trigger lines and synchronizes each one. It detects rising edges, queues the requests, and grants one exclusive active-low chip-select window at a time. Each window has a programmable dwell and a fixed guard gap. The block sits between the scan trigger sources and the shared scan/PCIe sampling resource, so only one channel drives chip-select at any time.

## Interface
- NCH, 4: number of requesting channels (2..8)
- GAP_CYC, 3: guard cycles with all chip-selects high between windows (≥1)
- DW, 16: width of dwell counter and dwell_cycles

- clk24m  in  1  single 24 MHz clock; all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  NCH  asynchronous scan trigger levels; a rising edge requests a window
- enable  in  1  when low, no new grants; pending requests keep latching
- dwell_cycles  in  DW  window length in clk24m cycles; sampled at grant; 0 is treated as 1
- abort  in  1  terminates the current window early
- cs_n  out  NCH  active-low chip-selects; at most one low
- gnt_id  out  $clog2(NCH)  index of the current or last granted channel
- busy  out  1  high in ACTIVE or GAP
- done  out  1  one-cycle pulse on normal (non-aborted) window completion

## Operation
- Per channel: 2-flop synchronizer, a third flop for edge detect, rise = s2 & ~s3.
- Per channel: pend[i] is set on rise and cleared at the edge where i is granted. If both occur in the same cycle, set wins, so the channel stays pending.
- FSM states IDLE, ACTIVE, GAP.
- IDLE: if enable and any pend, grant the first pending channel searching upward from gnt_id+1, modulo NCH. On that edge:
  - load counter with max(dwell_cycles,1)
  - gnt_id ← winner
  - go to ACTIVE
- ACTIVE: cs_n[gnt_id]=0 and the counter decrements each cycle.
  - When counter==1 and no abort: pulse done, go to GAP.
  - If abort: go to GAP immediately and do not pulse done.
- GAP: all cs_n=1; count GAP_CYC cycles, then go to IDLE.
- A rise on the active channel during ACTIVE or GAP re-arms pend; that channel is served later in round-robin order.
- enable deasserting during ACTIVE or GAP does not cut the window. It only blocks the next grant.
- Reset: cs_n all 1, gnt_id=NCH-1 (so channel 0 is searched first), busy=0, done=0, pend=0, synchronizer flops=0, state=IDLE.
- Reset asserted mid-window: cs_n returns to all 1 on that same edge; no done pulse.

## Timing
- req rises before edge E0: s1=1 after E0, s2=1 after E1, pend=1 after E2.
- If IDLE and enable, the grant happens at E3: cs_n low and busy high from E3.
- Edge-to-chip-select latency is 3 cycles after the first sampling edge.
- Window: cs_n low for exactly max(dwell_cycles,1) cycles.
- done is high in the cycle after the last low cycle, coincident with the first GAP cycle.
- Gap: all high for exactly GAP_CYC cycles. IDLE then occupies ≥1 cycle before the next grant.
- Back-to-back pending: window-to-window spacing is dwell + GAP_CYC + 1 cycles.
- abort sampled high in ACTIVE: cs_n high in the next cycle.
- abort is ignored outside ACTIVE.
- Outputs cs_n, gnt_id, busy and done are all registered; there are no combinational paths from inputs.

## Structure
- Shared package scan_pkg holds:
  - the state enum (IDLE/ACTIVE/GAP)
  - the default DW and GAP_CYC constants
  - the round-robin next-index function
- Sub-module scan_req_sync (synchronizer + edge detect, 1 bit) is instantiated NCH times.
- The pend register, arbiter, FSM and counters stay in scan_cs_sched.

## Test plan
- Reset then single edge: req[2] rises, dwell=5 → cs_n[2] low 3 cycles later for 5 cycles; done pulse; GAP 3 cycles all high; gnt_id=2.
- Simultaneous edges on req[0], req[1], req[3], dwell=2 → windows in order 0, 1, 3; each 2 cycles low, 3-cycle gaps; never two cs_n low together.
- Round-robin fairness: gnt_id=1 last, then ch0 and ch1 both pending → ch0 served before ch1.
- dwell_cycles=0 → 1-cycle window. Changing dwell_cycles mid-window from 8 to 2 → the window stays 8.
- abort on 3rd cycle of a 10-cycle window → cs_n high on the 4th cycle; no done; gap still 3 cycles.
- enable=0 with pend set → no grant. Re-edge on the active channel during its window → it is re-served after the others. rst asserted mid-window → cs_n all 1 next edge, pend cleared.
